run_supervisor: RTL and testbench
=================================

# run_supervisor

- Synthesizable run controller that sequences the core through reset, clock enable, first-fetch trigger, run and drain.
- Ends a run on halt-instruction detection, watchdog expiry or external abort, and reports why the run ended.
- Counts core cycles for the run.
- Sits beside `CoreTop`: drives the core reset, the clock-gate enable and `first_fetch_trigger`.

## Interface
- `CYCLE_CNT_W`, 32, cycle counter width
- `WDOG_W`, 16, watchdog counter/limit width
- `RESET_CYCLES`, 10, cycles `core_rstn` held low (≥1)
- `SETTLE_CYCLES`, 10, clocked cycles before trigger (≥1)
- `DRAIN_CYCLES`, 10, clocked cycles after termination (≥1)
- `HALT_INSTR`, 32'h0000006F, end-of-test instruction encoding
- `HALT_REPEAT`, 1, consecutive valid halt observations required (≥1)
- `clk` in 1 — sole clock
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — begin a run; sampled only in IDLE
- `abort` in 1 — force termination
- `wdog_limit` in `WDOG_W` — RUN cycles without kick before expiry; 0 disables; sampled on start acceptance
- `wdog_kick` in 1 — clears watchdog count
- `decode_instr` in 32 — core decode-stage instruction
- `decode_valid` in 1 — `decode_instr` qualifier
- `core_rstn` out 1 — core reset, active-low
- `core_clk_en` out 1 — clock-gate enable
- `first_fetch_trigger` out 1 — one-cycle go pulse
- `busy` out 1 — state ≠ IDLE
- `done` out 1 — one-cycle end-of-run pulse
- `status` out 2 — 00 none, 01 halted, 10 watchdog, 11 aborted
- `cycle_count` out `CYCLE_CNT_W` — cycles with `core_clk_en` high, this run

## Operation
- States: IDLE → RESET → SETTLE → GO → RUN → DRAIN → DONE → IDLE.
- IDLE
  - `start` accepted: clear `cycle_count`, `status` and the halt/watchdog counters, latch `wdog_limit`, go to RESET.
- RESET
  - `core_rstn`=0, `core_clk_en`=0, for `RESET_CYCLES` cycles.
- SETTLE
  - `core_rstn`=1, `core_clk_en`=1, for `SETTLE_CYCLES` cycles.
- GO
  - One cycle, `first_fetch_trigger`=1.
- RUN
  - Watchdog counter increments each RUN cycle; `wdog_kick` clears it to 0 instead. Expiry when the incremented value would equal the latched limit (limit ≠ 0).
  - Halt counter:
    - `decode_valid` with `decode_instr`==`HALT_INSTR`: increment.
    - `decode_valid` with any other instruction: clear.
    - `!decode_valid`: hold.
  - Halt fires when the counter reaches `HALT_REPEAT`.
- Termination in cycle t → DRAIN from t+1; `status` set at t+1.
  - Priority: abort(11) > halt(01) > watchdog(10).
  - `abort` also terminates from RESET/SETTLE/GO; that path goes straight to DRAIN with status 11.
- DRAIN
  - `core_clk_en`=1 for `DRAIN_CYCLES` cycles; `abort` ignored.
- DONE
  - One cycle, `done`=1, `core_clk_en`=0.
  - Then IDLE; `status` and `cycle_count` hold until the next accepted start.
- `core_rstn` is 0 only after `rst` (until first start leaves RESET) and in RESET. Otherwise it holds 1, so core state survives for memory dump.
- `start` outside IDLE is ignored. `abort` in IDLE/DONE is ignored.
- `cycle_count` saturates at all-ones; the watchdog counter cannot pass the limit.

## Timing
- All outputs registered.
- Reset values: state IDLE, `core_rstn`=0, `core_clk_en`=0, `first_fetch_trigger`=0, `busy`=0, `done`=0, `status`=00, `cycle_count`=0.
- `rst` mid-run returns to reset values on the next edge; no DONE pulse.
- `start` sampled at cycle 0:
  - RESET cycles 1..`RESET_CYCLES`.
  - SETTLE cycles `RESET_CYCLES`+1 .. `RESET_CYCLES`+`SETTLE_CYCLES`.
  - GO cycle `RESET_CYCLES`+`SETTLE_CYCLES`+1.
  - RUN begins the cycle after GO.
- Termination detected at t: DRAIN t+1..t+`DRAIN_CYCLES`, DONE at t+`DRAIN_CYCLES`+1.
- `cycle_count` reflects core_clk_en-high cycles up to the previous edge; final value is stable during DONE.

## Structure
- `run_supervisor_pkg`: state enum, status enum/encodings, status width.
- One sub-module `sat_counter`:
  - parametrised width, enable, synchronous clear, saturation flag.
  - Used for `cycle_count` and the watchdog.
- State dwell counts use one shared down-counter sized to the largest of the three cycle parameters.

## Test plan
Settings: `RESET_CYCLES`=4, `SETTLE_CYCLES`=2, `DRAIN_CYCLES`=3; `start` at cycle 0.
- Halt run: `wdog_limit`=0; valid 0x6F at cycle 20.
  - `core_rstn` low 1–4, `core_clk_en` rises 5, trigger at 7, DRAIN 21–23.
  - DONE at 24: `done`=1, `status`=01, `cycle_count`=19, `core_clk_en`=0.
- Watchdog: `wdog_limit`=8, no kick, no halt.
  - RUN 8–15, DRAIN 16–18, DONE 19, `status`=10.
- Kick: `wdog_limit`=8, kick every 5th RUN cycle for 100 cycles → no expiry; then valid 0x6F → `status`=01.
- `HALT_REPEAT`=2:
  - 0x6F, invalid cycle, 0x6F → terminate (status 01).
  - 0x6F, 0x13, 0x6F → no termination.
- Conflicts:
  - `abort`+halt same cycle → `status`=11.
  - `abort` in SETTLE → DRAIN next cycle, no trigger pulse.
  - `start` during RUN → ignored.
  - `rst` in RUN → all reset values next cycle.
- Saturation: `CYCLE_CNT_W`=4, halt after 30 RUN cycles → `cycle_count`=15.

Source files
------------

// File: rtl/run_supervisor_pkg.sv
// Shared types for the run supervisor: controller states, run-end status codes
// and a small helper used to size the shared dwell counter.
package run_supervisor_pkg;

    localparam int unsigned STATUS_W = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_SETTLE = 3'd2,
        S_GO     = 3'd3,
        S_RUN    = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    typedef enum logic [STATUS_W-1:0] {
        ST_NONE    = 2'b00,
        ST_HALTED  = 2'b01,
        ST_WDOG    = 2'b10,
        ST_ABORTED = 2'b11
    } status_e;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/run_supervisor_sat_counter.sv
// Up-counter that sticks at all-ones. Synchronous clear wins over enable.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_q;

    // count while enabled, stop at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !sat_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = &cnt_q;

endmodule

// File: rtl/run_supervisor.sv
// Run controller beside the core: sequences core reset, clock enable and the
// first-fetch trigger, ends the run on halt / watchdog / abort, reports why,
// and counts the clocked cycles of the run.
//
// state  | meaning
// IDLE   | waiting for start; status and cycle_count of last run held
// RESET  | core_rstn low, clock gated, RESET_CYCLES cycles
// SETTLE | core out of reset and clocked, SETTLE_CYCLES cycles
// GO     | one-cycle first_fetch_trigger
// RUN    | core running; halt detector and watchdog active
// DRAIN  | clock kept on DRAIN_CYCLES cycles after termination
// DONE   | one-cycle done pulse, clock gated
module run_supervisor
    import run_supervisor_pkg::*;
#(
    parameter int unsigned CYCLE_CNT_W   = 32,
    parameter int unsigned WDOG_W        = 16,
    parameter int unsigned RESET_CYCLES  = 10,
    parameter int unsigned SETTLE_CYCLES = 10,
    parameter int unsigned DRAIN_CYCLES  = 10,
    parameter logic [31:0] HALT_INSTR    = 32'h0000_006F,
    parameter int unsigned HALT_REPEAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WDOG_W-1:0]      wdog_limit,
    input  logic                   wdog_kick,
    input  logic [31:0]            decode_instr,
    input  logic                   decode_valid,
    output logic                   core_rstn,
    output logic                   core_clk_en,
    output logic                   first_fetch_trigger,
    output logic                   busy,
    output logic                   done,
    output logic [STATUS_W-1:0]    status,
    output logic [CYCLE_CNT_W-1:0] cycle_count
);

    // One dwell counter serves RESET, SETTLE and DRAIN; it holds N-1 down to 0.
    localparam int unsigned DWELL_MAX = max3(RESET_CYCLES, SETTLE_CYCLES, DRAIN_CYCLES);
    localparam int unsigned DWELL_W   = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
    localparam int unsigned HC_W      = $clog2(HALT_REPEAT + 1);

    localparam logic [DWELL_W-1:0] RESET_LOAD  = DWELL_W'(RESET_CYCLES - 1);
    localparam logic [DWELL_W-1:0] SETTLE_LOAD = DWELL_W'(SETTLE_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DRAIN_LOAD  = DWELL_W'(DRAIN_CYCLES - 1);
    localparam logic [HC_W-1:0]    HALT_TGT    = HC_W'(HALT_REPEAT);

    state_e              state_q;
    status_e             status_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [HC_W-1:0]     halt_cnt_q;
    logic [HC_W-1:0]     halt_cnt_d;
    logic [WDOG_W-1:0]   wdog_lim_q;
    logic                core_rstn_q;
    logic                clk_en_q;
    logic                trig_q;
    logic                busy_q;
    logic                done_q;

    logic                accept;
    logic                in_run;
    logic                is_halt;
    logic [HC_W-1:0]     halt_inc;
    logic                halt_fire;
    logic [WDOG_W-1:0]   wdog_cnt;
    logic [WDOG_W-1:0]   wdog_inc;
    logic                wdog_sat;
    logic                wdog_clr;
    logic                wdog_fire;
    logic [CYCLE_CNT_W-1:0] cyc_cnt;
    logic                cyc_sat;
    logic                term;
    status_e             term_status;

    assign accept   = (state_q == S_IDLE) && start;
    assign in_run   = (state_q == S_RUN);
    assign wdog_clr = accept || (in_run && wdog_kick);

    sat_counter #(.W(WDOG_W)) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr_i (wdog_clr),
        .en_i  (in_run),
        .cnt_o (wdog_cnt),
        .sat_o (wdog_sat)
    );

    sat_counter #(.W(CYCLE_CNT_W)) u_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (clk_en_q && !cyc_sat),
        .cnt_o (cyc_cnt),
        .sat_o (cyc_sat)
    );

    // termination detection and halt-streak bookkeeping for the current cycle
    always_comb begin
        is_halt    = decode_valid && (decode_instr == HALT_INSTR);
        halt_inc   = halt_cnt_q + 1'b1;
        halt_cnt_d = halt_cnt_q;
        if (is_halt) begin
            halt_cnt_d = halt_inc;
        end else if (decode_valid) begin
            halt_cnt_d = '0;
        end
        halt_fire = in_run && is_halt && (halt_inc == HALT_TGT);

        // sat guard keeps the +1 compare from wrapping when the limit is 0
        wdog_inc  = wdog_cnt + WDOG_W'(1);
        wdog_fire = in_run && !wdog_kick && (wdog_lim_q != '0) && !wdog_sat
                    && (wdog_inc == wdog_lim_q);

        term        = 1'b0;
        term_status = ST_ABORTED;
        case (state_q)
            S_RESET, S_SETTLE, S_GO: begin
                term = abort;
            end
            S_RUN: begin
                term = abort || halt_fire || wdog_fire;
                if (abort) begin
                    term_status = ST_ABORTED;
                end else if (halt_fire) begin
                    term_status = ST_HALTED;
                end else begin
                    term_status = ST_WDOG;
                end
            end
            default: begin
                term = 1'b0;
            end
        endcase
    end

    // sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            status_q    <= ST_NONE;
            dwell_q     <= '0;
            halt_cnt_q  <= '0;
            wdog_lim_q  <= '0;
            core_rstn_q <= 1'b0;
            clk_en_q    <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            done_q <= 1'b0;
            if (term) begin
                state_q     <= S_DRAIN;
                dwell_q     <= DRAIN_LOAD;
                status_q    <= term_status;
                core_rstn_q <= 1'b1;
                clk_en_q    <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            state_q     <= S_RESET;
                            dwell_q     <= RESET_LOAD;
                            status_q    <= ST_NONE;
                            halt_cnt_q  <= '0;
                            wdog_lim_q  <= wdog_limit;
                            core_rstn_q <= 1'b0;
                            clk_en_q    <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                    S_RESET: begin
                        if (dwell_q == '0) begin
                            state_q     <= S_SETTLE;
                            dwell_q     <= SETTLE_LOAD;
                            core_rstn_q <= 1'b1;
                            clk_en_q    <= 1'b1;
                        end else begin
                            dwell_q <= dwell_q - 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (dwell_q == '0) begin
                            state_q <= S_GO;
                            trig_q  <= 1'b1;
                        end else begin
                            dwell_q <= dwell_q - 1'b1;
                        end
                    end
                    S_GO: begin
                        state_q <= S_RUN;
                    end
                    S_RUN: begin
                        halt_cnt_q <= halt_cnt_d;
                    end
                    S_DRAIN: begin
                        if (dwell_q == '0) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            clk_en_q <= 1'b0;
                        end else begin
                            dwell_q <= dwell_q - 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        clk_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign core_rstn           = core_rstn_q;
    assign core_clk_en         = clk_en_q;
    assign first_fetch_trigger = trig_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign status              = status_q;
    assign cycle_count         = cyc_cnt;

endmodule

// File: tb/tb_run_supervisor.sv
// Bench for run_supervisor: two instances (halt repeat 1 / 32-bit count and
// halt repeat 2 / 4-bit count) share one stimulus stream. Each run is planned
// up front; a plan-level model predicts when and why each instance ends and
// pushes that into a per-instance queue, and a monitor pops on every done pulse.
module tb_run_supervisor;

    localparam int R = 4;
    localparam int S = 2;
    localparam int D = 3;
    localparam logic [31:0] HALT = 32'h0000_006F;
    localparam int MAXC = 200;

    typedef struct {
        int          done_cyc;
        int          trig_cyc;
        int          rstn_low;
        int          clken;
        logic [1:0]  status;
        longint      count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wdog_kick = 1'b0;
    logic        decode_valid = 1'b0;
    logic [15:0] wdog_limit = '0;
    logic [31:0] decode_instr = '0;

    logic        rstn_a, clken_a, trig_a, busy_a, done_a;
    logic [1:0]  status_a;
    logic [31:0] count_a;
    logic        rstn_b, clken_b, trig_b, busy_b, done_b;
    logic [1:0]  status_b;
    logic [3:0]  count_b;

    run_supervisor #(
        .CYCLE_CNT_W(32), .WDOG_W(16), .RESET_CYCLES(R), .SETTLE_CYCLES(S),
        .DRAIN_CYCLES(D), .HALT_INSTR(HALT), .HALT_REPEAT(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .wdog_limit(wdog_limit), .wdog_kick(wdog_kick),
        .decode_instr(decode_instr), .decode_valid(decode_valid),
        .core_rstn(rstn_a), .core_clk_en(clken_a), .first_fetch_trigger(trig_a),
        .busy(busy_a), .done(done_a), .status(status_a), .cycle_count(count_a)
    );

    run_supervisor #(
        .CYCLE_CNT_W(4), .WDOG_W(16), .RESET_CYCLES(R), .SETTLE_CYCLES(S),
        .DRAIN_CYCLES(D), .HALT_INSTR(HALT), .HALT_REPEAT(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .wdog_limit(wdog_limit), .wdog_kick(wdog_kick),
        .decode_instr(decode_instr), .decode_valid(decode_valid),
        .core_rstn(rstn_b), .core_clk_en(clken_b), .first_fetch_trigger(trig_b),
        .busy(busy_b), .done(done_b), .status(status_b), .cycle_count(count_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // run plan: inputs per cycle relative to the start cycle (cycle 0)
    logic        p_valid [MAXC+1];
    logic [31:0] p_instr [MAXC+1];
    logic        p_kick  [MAXC+1];
    logic        p_abort [MAXC+1];
    logic [15:0] p_limit;
    int          p_len;
    int          p_xstart;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int lowc[2];
    int enc[2];
    int trigc[2];
    int ntrig[2];

    task automatic mon_clear(input int i);
        lowc[i]  = 0;
        enc[i]   = 0;
        trigc[i] = -1;
        ntrig[i] = 0;
    endtask

    task automatic mon_dut(input int i, input logic rstn, input logic clken,
                           input logic trig, input logic busy, input logic dn,
                           input logic [1:0] st, input logic [31:0] cnt);
        exp_t e;
        string n;
        n = (i == 0) ? "A" : "B";
        if (busy && !rstn) lowc[i]++;
        if (busy && clken) enc[i]++;
        if (trig) begin
            ntrig[i]++;
            trigc[i] = cyc;
        end
        if (dn) begin
            if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL %s.unexpected_done: done=1 at cycle %0d, expected no done", n, cyc);
            end else begin
                if (i == 0) e = q_a.pop_front();
                else        e = q_b.pop_front();
                check({n, ".done_cycle"}, cyc, e.done_cyc);
                check({n, ".status"}, st, e.status);
                check({n, ".cycle_count"}, cnt, e.count);
                check({n, ".clk_en_in_done"}, clken, 0);
                check({n, ".busy_in_done"}, busy, 1);
                check({n, ".trigger_cycle"}, trigc[i], e.trig_cyc);
                check({n, ".trigger_pulses"}, ntrig[i], (e.trig_cyc >= 0) ? 1 : 0);
                check({n, ".rstn_low_cycles"}, lowc[i], e.rstn_low);
                check({n, ".clk_en_cycles"}, enc[i], e.clken);
            end
            mon_clear(i);
        end
    endtask

    // monitor: samples both instances mid-cycle and scores each done pulse
    always @(negedge clk) begin
        if (rst) begin
            mon_clear(0);
            mon_clear(1);
        end else begin
            mon_dut(0, rstn_a, clken_a, trig_a, busy_a, done_a, status_a, count_a);
            mon_dut(1, rstn_b, clken_b, trig_b, busy_b, done_b, status_b, {28'd0, count_b});
        end
    end

    // Plan-level reference: walk the planned cycles, find the first cycle that
    // ends the run, then derive phase lengths from the fixed timeline.
    function automatic exp_t model(input int hr, input int cw);
        exp_t       e;
        int         t;
        logic [1:0] st;
        int         halt;
        int         wd;
        bit         h;
        bit         w;
        int         first_en;
        longint     maxv;
        t = -1; st = 2'b11; halt = 0; wd = 0;
        for (int c = 1; c <= p_len && t < 0; c++) begin
            if (c <= R + S + 1) begin
                if (p_abort[c]) begin t = c; st = 2'b11; end
            end else begin
                h = 1'b0;
                w = 1'b0;
                if (p_valid[c]) begin
                    if (p_instr[c] == HALT) begin
                        halt++;
                        h = (halt == hr);
                    end else begin
                        halt = 0;
                    end
                end
                if (p_kick[c]) wd = 0;
                else begin
                    wd++;
                    w = (p_limit != 0) && (wd == int'(p_limit));
                end
                if (p_abort[c])  begin t = c; st = 2'b11; end
                else if (h)      begin t = c; st = 2'b01; end
                else if (w)      begin t = c; st = 2'b10; end
            end
        end
        if (t < 0) begin t = p_len; st = 2'b11; end
        maxv       = (longint'(1) << cw) - 1;
        first_en   = (t + 1 < R + 1) ? t + 1 : R + 1;
        e.done_cyc = t + D + 1;
        e.trig_cyc = (t >= R + S + 1) ? R + S + 1 : -1;
        e.rstn_low = (t < R) ? t : R;
        e.clken    = t + D - first_en + 1;
        e.status   = st;
        e.count    = (longint'(e.clken) > maxv) ? maxv : longint'(e.clken);
        return e;
    endfunction

    task automatic clear_plan(input int len);
        for (int c = 0; c <= MAXC; c++) begin
            p_valid[c] = 1'b0;
            p_instr[c] = 32'h0000_0013;
            p_kick[c]  = 1'b0;
            p_abort[c] = 1'b0;
        end
        p_len       = len;
        p_limit     = '0;
        p_xstart    = 0;
        p_abort[len] = 1'b1;
    endtask

    task automatic put_halt(input int c);
        p_valid[c] = 1'b1;
        p_instr[c] = HALT;
    endtask

    task automatic drive_idle();
        start = 1'b0; abort = 1'b0; wdog_kick = 1'b0;
        decode_valid = 1'b0; decode_instr = '0;
    endtask

    task automatic run_plan();
        exp_t ea;
        exp_t eb;
        int   tmin;
        int   t0;
        int   k;
        ea = model(1, 32);
        eb = model(2, 4);
        tmin = ((ea.done_cyc < eb.done_cyc) ? ea.done_cyc : eb.done_cyc) - D - 1;
        if (p_xstart > tmin) p_xstart = tmin;
        @(posedge clk); #1;
        t0 = cyc;
        drive_idle();
        start = 1'b1;
        wdog_limit = p_limit;
        ea.done_cyc += t0;
        eb.done_cyc += t0;
        if (ea.trig_cyc >= 0) ea.trig_cyc += t0;
        if (eb.trig_cyc >= 0) eb.trig_cyc += t0;
        q_a.push_back(ea);
        q_b.push_back(eb);
        for (int c = 1; c <= p_len; c++) begin
            @(posedge clk); #1;
            start        = (c == p_xstart);
            wdog_limit   = 16'($urandom);
            abort        = p_abort[c];
            wdog_kick    = p_kick[c];
            decode_valid = p_valid[c];
            decode_instr = p_instr[c];
        end
        @(posedge clk); #1;
        drive_idle();
        k = 0;
        while ((busy_a || busy_b) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still high after 200 cycles, expected idle");
        end
        repeat (3) @(posedge clk);
        #1;
        check("A.status_hold", status_a, ea.status);
        check("A.count_hold", count_a, ea.count);
        check("B.status_hold", status_b, eb.status);
        check("B.count_hold", count_b, eb.count);
    endtask

    task automatic check_reset(input string n);
        check({n, ".A.core_rstn"}, rstn_a, 0);
        check({n, ".A.core_clk_en"}, clken_a, 0);
        check({n, ".A.trigger"}, trig_a, 0);
        check({n, ".A.busy"}, busy_a, 0);
        check({n, ".A.done"}, done_a, 0);
        check({n, ".A.status"}, status_a, 0);
        check({n, ".A.cycle_count"}, count_a, 0);
        check({n, ".B.core_rstn"}, rstn_b, 0);
        check({n, ".B.busy"}, busy_b, 0);
        check({n, ".B.status"}, status_b, 0);
        check({n, ".B.cycle_count"}, count_b, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // halt run: 0x6F at cycle 20
        clear_plan(30);
        put_halt(20);
        run_plan();

        // watchdog, limit 8, no kick
        clear_plan(40);
        p_limit = 16'd8;
        run_plan();

        // kick every 5th RUN cycle for 100 cycles, then two halts
        clear_plan(120);
        p_limit = 16'd8;
        for (int c = 8; c < 108; c++) p_kick[c] = ((c - 8) % 5 == 4);
        put_halt(110);
        put_halt(111);
        run_plan();

        // halt, invalid, halt
        clear_plan(25);
        put_halt(10);
        put_halt(12);
        run_plan();

        // halt, other instruction, halt
        clear_plan(25);
        put_halt(10);
        p_valid[11] = 1'b1;
        p_instr[11] = 32'h0000_0013;
        put_halt(12);
        run_plan();

        // abort and halt in the same cycle
        clear_plan(30);
        put_halt(15);
        put_halt(16);
        p_abort[15] = 1'b1;
        run_plan();

        // abort in SETTLE, abort in RESET
        clear_plan(20);
        p_abort[6] = 1'b1;
        run_plan();
        clear_plan(20);
        p_abort[2] = 1'b1;
        run_plan();

        // start during RUN is ignored
        clear_plan(30);
        p_xstart = 12;
        put_halt(20);
        put_halt(21);
        run_plan();

        // long run: 4-bit count saturates
        clear_plan(60);
        put_halt(38);
        put_halt(39);
        run_plan();

        // reset mid-run
        @(posedge clk); #1;
        start = 1'b1;
        wdog_limit = '0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("mid_rst");
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // randomized plans
        for (int n = 0; n < 30; n++) begin
            clear_plan($urandom_range(8, 90));
            p_limit = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 25));
            for (int c = 1; c <= p_len; c++) begin
                p_valid[c] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 4) == 0)      p_instr[c] = HALT;
                else if ($urandom_range(0, 1) == 1) p_instr[c] = 32'h0000_0013;
                else                                p_instr[c] = $urandom;
                p_kick[c] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 59) == 0) p_abort[c] = 1'b1;
            end
            p_xstart = ($urandom_range(0, 1) == 1) ? $urandom_range(1, p_len) : 0;
            run_plan();
        end

        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: %0d/%0d runs never signalled done, expected 0/0",
                     q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
